// File: rtl/uk101_save_pkg.sv
// Shared types and constants for the UK101 serial-save capture block.
// Optional NUL/DEL filtering is selected with the UK101_SAVE_FILTER_EN macro.
package uk101_save_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        UPLOAD  = 2'd3
    } state_t;

    localparam logic [7:0] NUL_CHAR = 8'h00;
    localparam logic [7:0] DEL_CHAR = 8'h7F;

    localparam int unsigned ADDR_W_DEFAULT       = 13;
    localparam int unsigned IDLE_TIMEOUT_DEFAULT = 50_000_000;
    localparam int unsigned CNT_W                = 26;

endpackage

// File: rtl/uk101_save_ram.sv
// Simple dual-port byte buffer: one write port, one registered read port, single clock.
module uk101_save_ram #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [7:0] mem [DEPTH];

    // Contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uk101_save_capture.sv
// Captures the UK101 ACIA transmit stream into a buffer and serves it to hps_io uploads.
// Define UK101_SAVE_FILTER_EN to drop NUL/DEL padding bytes from the capture.
module uk101_save_capture
    import uk101_save_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            enable,
    input  logic            tx_strobe,
    input  logic [7:0]      tx_data,
    input  logic            ioctl_upload,
    input  logic            ioctl_rd,
    input  logic [15:0]     ioctl_addr,
    output logic [7:0]      ioctl_din,
    output logic            save_ready,
    output logic [ADDR_W:0] save_len,
    output logic            overflow,
    output logic            busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] FULL_LEN    = LEN_W'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IDLE_TIMEOUT);

    state_t             state;
    state_t             state_d;
    logic [LEN_W-1:0]   len_d;
    logic               ovf_d;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic               ready_d;
    logic               busy_d;
    logic               upload_q;

    logic               keep_c;
    logic               take_c;
    logic               drop_c;
    logic               upload_rise_c;
    logic               upload_fall_c;
    logic               we_c;
    logic [ADDR_W-1:0]  waddr_c;
    logic               in_range_c;

    logic               rd_q;
    logic               in_range_q;
    logic [7:0]         ram_q;

    // Byte filter: NUL/DEL still count as activity but are not stored when enabled.
`ifdef UK101_SAVE_FILTER_EN
    assign keep_c = (tx_data != NUL_CHAR) && (tx_data != DEL_CHAR);
`else
    assign keep_c = 1'b1;
`endif

    assign take_c        = tx_strobe && keep_c && (save_len != FULL_LEN);
    assign drop_c        = tx_strobe && keep_c && (save_len == FULL_LEN);
    assign upload_rise_c = ioctl_upload && !upload_q;
    assign upload_fall_c = !ioctl_upload && upload_q;
    assign waddr_c       = save_len[ADDR_W-1:0];
    assign in_range_c    = (state == UPLOAD) && (32'(ioctl_addr) < 32'(save_len));

    // Next-state, length, overflow and idle-counter logic.
    always_comb begin
        state_d = state;
        len_d   = save_len;
        ovf_d   = overflow;
        cnt_d   = idle_cnt;
        we_c    = 1'b0;

        case (state)
            IDLE: begin
                cnt_d = '0;
                if (tx_strobe && enable) begin
                    state_d = CAPTURE;
                    if (take_c) begin
                        we_c  = 1'b1;
                        len_d = save_len + LEN_W'(1);
                    end
                end
            end
            CAPTURE: begin
                if (tx_strobe) begin
                    cnt_d = '0;
                    if (take_c) begin
                        we_c  = 1'b1;
                        len_d = save_len + LEN_W'(1);
                    end else if (drop_c) begin
                        ovf_d = 1'b1;
                    end
                end else if ((idle_cnt != TIMEOUT_CNT) && (idle_cnt != '1)) begin
                    cnt_d = idle_cnt + CNT_W'(1);
                end
                // A strobe on the expiry edge keeps the capture open.
                if (!enable || (!tx_strobe && (idle_cnt == TIMEOUT_CNT))) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (tx_strobe && enable) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    if (take_c) begin
                        we_c  = 1'b1;
                        len_d = save_len + LEN_W'(1);
                    end else if (drop_c) begin
                        ovf_d = 1'b1;
                    end
                end else if (upload_rise_c) begin
                    state_d = UPLOAD;
                end
            end
            UPLOAD: begin
                if (upload_fall_c) begin
                    state_d = IDLE;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == HOLD) && (len_d != '0);
        busy_d  = (state_d == CAPTURE) || (state_d == UPLOAD);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            save_len   <= '0;
            overflow   <= 1'b0;
            idle_cnt   <= '0;
            save_ready <= 1'b0;
            busy       <= 1'b0;
            upload_q   <= 1'b0;
        end else begin
            state      <= state_d;
            save_len   <= len_d;
            overflow   <= ovf_d;
            idle_cnt   <= cnt_d;
            save_ready <= ready_d;
            busy       <= busy_d;
            upload_q   <= ioctl_upload;
        end
    end

    uk101_save_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (tx_data),
        .re    (ioctl_rd),
        .raddr (ioctl_addr[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    // Read return: out-of-range or non-upload reads yield zero; data holds between reads.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_q       <= 1'b0;
            in_range_q <= 1'b0;
            ioctl_din  <= 8'h00;
        end else begin
            rd_q       <= ioctl_rd;
            in_range_q <= in_range_c;
            if (rd_q) begin
                ioctl_din <= in_range_q ? ram_q : 8'h00;
            end
        end
    end

endmodule
